// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared constants for the MEM-stage cache access controller:
//   state_t          - controller FSM state encoding (2 bits)
//   DEFAULT_TIMEOUT  - default maximum number of WAIT cycles before error
//   PERF_CNT_WIDTH   - width of the hit/miss performance counters
// ---------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam int DEFAULT_TIMEOUT = 1023;
    localparam int PERF_CNT_WIDTH  = 32;

endpackage

// File: rtl/mem_access_ctrl_perf.sv
// ---------------------------------------------------------------------------
// mem_perf_counter
// Hit/miss event counters for the cache access controller. Both counters
// wrap modulo 2^32.
//
// Build option: MEM_ACCESS_CTRL_PERF_CNT_EN
//   defined   - counters are implemented
//   undefined - outputs tied to zero, no counter registers
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   hit_pulse  in   one-cycle pulse per access completing as a hit
//   miss_pulse in   one-cycle pulse per access completing as a miss
//   hit_cnt    out  number of hits
//   miss_cnt   out  number of misses
// ---------------------------------------------------------------------------
module mem_perf_counter
    import mem_access_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hit_pulse,
    input  logic                      miss_pulse,
    output logic [PERF_CNT_WIDTH-1:0] hit_cnt,
    output logic [PERF_CNT_WIDTH-1:0] miss_cnt
);

`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] hit_cnt_q,  hit_cnt_d;
    logic [PERF_CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q  + PERF_CNT_WIDTH'(hit_pulse);
        miss_cnt_d = miss_cnt_q + PERF_CNT_WIDTH'(miss_pulse);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    // Inputs are intentionally left without a load when counting is disabled.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, reset, hit_pulse, miss_pulse};

    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage load/store controller in front of a cache with a ready/valid
// style handshake. Issues one cache request per aligned access, stalls the
// pipeline until the cache answers (or a WAIT timeout fires), and flags
// misaligned accesses and timeouts on a sticky err output.
//
// Build option: MEM_ACCESS_CTRL_PERF_CNT_EN enables hit/miss counters
// (see mem_perf_counter); without it hit_cnt/miss_cnt read as zero.
//
// Parameters: ADDR_WIDTH, DATA_WIDTH, TIMEOUT (max WAIT cycles)
// Ports:
//   clk, reset (async, active-low)
//   req_valid/mem_read/mem_write/req_addr/req_wdata  pipeline request
//   stall, rdata, rdata_valid, err                   pipeline response
//   c_is_input_valid/c_addr/c_mem_rw/c_din           cache request
//   c_is_ready/c_is_output_valid/c_dout              cache response
//   hit_cnt, miss_cnt                                performance counters
//
// state | meaning
// IDLE  | waiting for an aligned request while the cache is ready
// REQ   | one-cycle request strobe to the cache
// WAIT  | waiting for cache completion, timeout counter running
// DONE  | result presented for one cycle, pipeline released
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      stall,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      rdata_valid,
    output logic                      err,
    output logic                      c_is_input_valid,
    output logic [ADDR_WIDTH-1:0]     c_addr,
    output logic                      c_mem_rw,
    output logic [DATA_WIDTH-1:0]     c_din,
    input  logic                      c_is_ready,
    input  logic                      c_is_output_valid,
    input  logic [DATA_WIDTH-1:0]     c_dout,
    output logic [PERF_CNT_WIDTH-1:0] hit_cnt,
    output logic [PERF_CNT_WIDTH-1:0] miss_cnt
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rw_q, rw_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic                    req_any, req_aligned;
    logic                    hit_pulse, miss_pulse;

    assign req_any     = req_valid && (mem_read || mem_write);
    assign req_aligned = req_any && (req_addr[1:0] == 2'b00);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rw_d       = rw_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;
        hit_pulse  = 1'b0;
        miss_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_any && !req_aligned) begin
                    err_d = 1'b1;
                end else if (req_aligned && c_is_ready) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // write wins when both read and write are requested
                    rw_d    = mem_write;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (c_is_output_valid) begin
                    if (!rw_q) begin
                        rdata_d = c_dout;
                    end
                    hit_pulse  = (wait_cnt_q == '0);
                    miss_pulse = (wait_cnt_q != '0);
                    state_d    = ST_DONE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    wait_cnt_d = CNT_SAT;
                    err_d      = 1'b1;
                    rdata_d    = '0;
                    state_d    = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rw_q       <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rw_q       <= rw_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The IDLE term looks straight at the request inputs, so it is gated by
    // reset to keep stall low while reset is held.
    assign stall = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                   ((state_q == ST_IDLE) && req_aligned && reset);

    assign c_is_input_valid = (state_q == ST_REQ);
    assign rdata_valid      = (state_q == ST_DONE) && !rw_q;
    assign c_addr           = addr_q;
    assign c_mem_rw         = rw_q;
    assign c_din            = wdata_q;
    assign rdata            = rdata_q;
    assign err              = err_q;

    mem_perf_counter u_perf (
        .clk        (clk),
        .reset      (reset),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. Instance u_dut uses the default
// TIMEOUT; instance u_dut_to uses TIMEOUT=8 for the timeout scenario.
// Inputs change 1ns after the rising edge, outputs are checked 1-2ns after.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_CTRL_PERF_CNT_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        req_valid, mem_read, mem_write;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rdata_valid, err;
    logic [31:0] rdata;
    logic        c_is_input_valid, c_mem_rw;
    logic [31:0] c_addr, c_din;
    logic        c_is_ready, c_is_output_valid;
    logic [31:0] c_dout;
    logic [31:0] hit_cnt, miss_cnt;

    logic        b_req_valid, b_mem_read, b_mem_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_stall, b_rdata_valid, b_err;
    logic [31:0] b_rdata;
    logic        b_civ, b_c_mem_rw;
    logic [31:0] b_c_addr, b_c_din;
    logic        b_c_is_ready, b_c_ovalid;
    logic [31:0] b_c_dout;
    logic [31:0] b_hit_cnt, b_miss_cnt;

    int total = 0;
    int bad   = 0;
    int hold_bad;

    mem_access_ctrl u_dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .stall             (stall),
        .rdata             (rdata),
        .rdata_valid       (rdata_valid),
        .err               (err),
        .c_is_input_valid  (c_is_input_valid),
        .c_addr            (c_addr),
        .c_mem_rw          (c_mem_rw),
        .c_din             (c_din),
        .c_is_ready        (c_is_ready),
        .c_is_output_valid (c_is_output_valid),
        .c_dout            (c_dout),
        .hit_cnt           (hit_cnt),
        .miss_cnt          (miss_cnt)
    );

    mem_access_ctrl #(.TIMEOUT(8)) u_dut_to (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (b_req_valid),
        .mem_read          (b_mem_read),
        .mem_write         (b_mem_write),
        .req_addr          (b_req_addr),
        .req_wdata         (b_req_wdata),
        .stall             (b_stall),
        .rdata             (b_rdata),
        .rdata_valid       (b_rdata_valid),
        .err               (b_err),
        .c_is_input_valid  (b_civ),
        .c_addr            (b_c_addr),
        .c_mem_rw          (b_c_mem_rw),
        .c_din             (b_c_din),
        .c_is_ready        (b_c_is_ready),
        .c_is_output_valid (b_c_ovalid),
        .c_dout            (b_c_dout),
        .hit_cnt           (b_hit_cnt),
        .miss_cnt          (b_miss_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        req_addr = '0; req_wdata = '0;
        c_is_ready = 1'b1; c_is_output_valid = 1'b0; c_dout = '0;
        b_req_valid = 1'b0; b_mem_read = 1'b0; b_mem_write = 1'b0;
        b_req_addr = '0; b_req_wdata = '0;
        b_c_is_ready = 1'b1; b_c_ovalid = 1'b0; b_c_dout = '0;

        // reset values
        step(); step();
        chk("rst_stall",  64'(stall),            64'd0);
        chk("rst_rdata",  64'(rdata),            64'd0);
        chk("rst_rvalid", 64'(rdata_valid),      64'd0);
        chk("rst_err",    64'(err),              64'd0);
        chk("rst_civ",    64'(c_is_input_valid), 64'd0);
        chk("rst_caddr",  64'(c_addr),           64'd0);
        chk("rst_rw",     64'(c_mem_rw),         64'd0);
        chk("rst_din",    64'(c_din),            64'd0);
        chk("rst_hit",    64'(hit_cnt),          64'd0);
        chk("rst_miss",   64'(miss_cnt),         64'd0);
        reset = 1'b1;
        step();

        // load 0x100, hit in first WAIT cycle
        req_valid = 1'b1; mem_read = 1'b1; req_addr = 32'h100; #1;
        chk("s1_stall_idle", 64'(stall), 64'd1);
        step();
        req_valid = 1'b0; mem_read = 1'b0; #1;
        chk("s1_civ",        64'(c_is_input_valid), 64'd1);
        chk("s1_caddr",      64'(c_addr),           64'h100);
        chk("s1_rw",         64'(c_mem_rw),         64'd0);
        chk("s1_stall_req",  64'(stall),            64'd1);
        step();
        chk("s1_civ_wait",   64'(c_is_input_valid), 64'd0);
        chk("s1_stall_wait", 64'(stall),            64'd1);
        c_is_output_valid = 1'b1; c_dout = 32'hDEADBEEF;
        step();
        c_is_output_valid = 1'b0; c_dout = '0;
        chk("s1_rdata",      64'(rdata),       64'hDEADBEEF);
        chk("s1_rvalid",     64'(rdata_valid), 64'd1);
        chk("s1_stall_done", 64'(stall),       64'd0);
        step();
        chk("s1_rvalid_off", 64'(rdata_valid), 64'd0);
        chk("s1_hit",        64'(hit_cnt),     64'(PERF_ON));
        chk("s1_miss",       64'(miss_cnt),    64'd0);

        // store 0x12345678 to 0x200, response after 20 WAIT cycles
        req_valid = 1'b1; mem_write = 1'b1; req_addr = 32'h200; req_wdata = 32'h12345678; #1;
        chk("s2_stall_idle", 64'(stall), 64'd1);
        step();
        req_valid = 1'b0; mem_write = 1'b0; req_addr = '0; req_wdata = '0; #1;
        chk("s2_civ", 64'(c_is_input_valid), 64'd1);
        chk("s2_rw",  64'(c_mem_rw),         64'd1);
        chk("s2_din", 64'(c_din),            64'h12345678);
        step();
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (c_mem_rw !== 1'b1 || c_din !== 32'h12345678 || c_addr !== 32'h200 ||
                stall !== 1'b1 || c_is_input_valid !== 1'b0)
                hold_bad++;
            step();
        end
        chk("s2_hold", 64'(hold_bad), 64'd0);
        c_is_output_valid = 1'b1; c_dout = 32'hAAAA5555;
        step();
        c_is_output_valid = 1'b0; c_dout = '0;
        chk("s2_rvalid",     64'(rdata_valid), 64'd0);
        chk("s2_rdata_kept", 64'(rdata),       64'hDEADBEEF);
        chk("s2_stall_done", 64'(stall),       64'd0);
        step();
        chk("s2_din_idle",   64'(c_din),    64'h12345678);
        chk("s2_miss",       64'(miss_cnt), 64'(PERF_ON));
        chk("s2_hit",        64'(hit_cnt),  64'(PERF_ON));
        chk("s2_err",        64'(err),      64'd0);

        // pending load while cache not ready for 5 cycles
        c_is_ready = 1'b0; req_valid = 1'b1; mem_read = 1'b1; req_addr = 32'h300;
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (stall !== 1'b1 || c_is_input_valid !== 1'b0) hold_bad++;
            step();
        end
        chk("s4_wait_ready", 64'(hold_bad), 64'd0);
        c_is_ready = 1'b1; #1;
        chk("s4_civ_idle", 64'(c_is_input_valid), 64'd0);
        step();
        req_valid = 1'b0; mem_read = 1'b0; #1;
        chk("s4_civ",   64'(c_is_input_valid), 64'd1);
        chk("s4_caddr", 64'(c_addr),           64'h300);
        step();
        c_is_output_valid = 1'b1; c_dout = 32'h0BADF00D;
        step();
        c_is_output_valid = 1'b0; c_dout = '0;
        chk("s4_rdata",  64'(rdata),       64'h0BADF00D);
        chk("s4_rvalid", 64'(rdata_valid), 64'd1);
        step();
        chk("s4_hit", 64'(hit_cnt), 64'(2 * PERF_ON));

        // misaligned load
        req_valid = 1'b1; mem_read = 1'b1; req_addr = 32'h103; #1;
        chk("s3_stall_pre", 64'(stall), 64'd0);
        chk("s3_err_pre",   64'(err),   64'd0);
        step();
        chk("s3_err",   64'(err),              64'd1);
        chk("s3_civ",   64'(c_is_input_valid), 64'd0);
        chk("s3_stall", 64'(stall),            64'd0);
        step();
        chk("s3_civ2",  64'(c_is_input_valid), 64'd0);
        req_valid = 1'b0; mem_read = 1'b0;
        step();
        chk("s3_err_sticky", 64'(err), 64'd1);

        // TIMEOUT=8 instance: a hit load first, then a load with no response
        b_req_valid = 1'b1; b_mem_read = 1'b1; b_req_addr = 32'h500;
        step();
        b_req_valid = 1'b0; b_mem_read = 1'b0; #1;
        chk("to_civ",   64'(b_civ),      64'd1);
        chk("to_caddr", 64'(b_c_addr),   64'h500);
        chk("to_rw",    64'(b_c_mem_rw), 64'd0);
        chk("to_din",   64'(b_c_din),    64'd0);
        step();
        b_c_ovalid = 1'b1; b_c_dout = 32'h11111111;
        step();
        b_c_ovalid = 1'b0; b_c_dout = '0;
        chk("to_rdata_hit", 64'(b_rdata), 64'h11111111);
        step();
        b_req_valid = 1'b1; b_mem_read = 1'b1; b_req_addr = 32'h504;
        step();
        b_req_valid = 1'b0; b_mem_read = 1'b0;
        step();
        hold_bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (b_err !== 1'b0 || b_stall !== 1'b1) hold_bad++;
            step();
        end
        chk("to_wait8",       64'(hold_bad),      64'd0);
        chk("to_err",         64'(b_err),         64'd1);
        chk("to_rdata_zero",  64'(b_rdata),       64'd0);
        chk("to_rvalid",      64'(b_rdata_valid), 64'd1);
        chk("to_stall_done",  64'(b_stall),       64'd0);
        step();
        chk("to_rvalid_off",  64'(b_rdata_valid), 64'd0);
        chk("to_err_sticky",  64'(b_err),         64'd1);
        chk("to_civ_idle",    64'(b_civ),         64'd0);

        // reset asserted while in WAIT
        req_valid = 1'b1; mem_read = 1'b1; req_addr = 32'h600;
        step();
        step();
        chk("rw_stall_wait", 64'(stall), 64'd1);
        reset = 1'b0; #1;
        chk("rw_stall",  64'(stall),            64'd0);
        chk("rw_rdata",  64'(rdata),            64'd0);
        chk("rw_rvalid", 64'(rdata_valid),      64'd0);
        chk("rw_err",    64'(err),              64'd0);
        chk("rw_civ",    64'(c_is_input_valid), 64'd0);
        chk("rw_caddr",  64'(c_addr),           64'd0);
        chk("rw_rw",     64'(c_mem_rw),         64'd0);
        chk("rw_din",    64'(c_din),            64'd0);
        chk("rw_hit",    64'(hit_cnt),          64'd0);
        chk("rw_miss",   64'(miss_cnt),         64'd0);
        chk("rw_b_err",  64'(b_err),            64'd0);
        chk("rw_b_hit",  64'(b_hit_cnt),        64'd0);
        chk("rw_b_miss", 64'(b_miss_cnt),       64'd0);
        step();
        chk("rw_stall_held", 64'(stall), 64'd0);
        req_valid = 1'b0; mem_read = 1'b0; reset = 1'b1;
        step();
        chk("rw_post_civ",  64'(c_is_input_valid), 64'd0);
        chk("rw_post_hit",  64'(hit_cnt),          64'd0);
        chk("rw_post_miss", 64'(miss_cnt),         64'd0);
        chk("rw_post_err",  64'(err),              64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
